// File: rtl/outram_wr.sv
// outram_wr: drains packed bytes from the output packer into IO RAM port B.
// Define OUTRAM_HDR_EN to prefix the stream with a 16-bit big-endian byte count.
module outram_wr #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              end_req,
  input  logic              write_data,
  input  logic              write_sp,
  input  logic              valid_dcnt,
  input  logic              tc_outreg,
  input  logic [7:0]        lzw_byte,
  output logic              read_data,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_din_b,
  output logic [ADDR_W:0]   byte_cnt,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    HDR0  = 3'd3,
    HDR1  = 3'd4,
    DONE  = 3'd5
  } state_t;

`ifdef OUTRAM_HDR_EN
  localparam logic [ADDR_W:0] BASE   = (ADDR_W+1)'(2);
  localparam state_t          S_TAIL = HDR0;
`else
  localparam logic [ADDR_W:0] BASE   = '0;
  localparam state_t          S_TAIL = DONE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_end_pend;
  logic [ADDR_W:0]   r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_din;
  logic [ADDR_W:0]   r_byte_cnt;
  logic              r_done;
  logic              r_ovf;
  logic              w_strobe;
  logic              w_pop;
  logic              w_full;

  assign w_strobe = write_data | write_sp;
  // The pointer carries one extra bit; it sets once the last address is used.
  assign w_full   = r_ptr[ADDR_W];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        // A packer write always wins; the pop simply retries next cycle.
        w_pop = valid_dcnt & ~w_strobe;
        if (r_end_pend && !valid_dcnt && !w_strobe)
          w_state_nxt = tc_outreg ? S_TAIL : FLUSH;
      end
      FLUSH: begin
        w_pop       = 1'b1;
        w_state_nxt = S_TAIL;
      end
`ifdef OUTRAM_HDR_EN
      HDR0: w_state_nxt = HDR1;
      HDR1: w_state_nxt = DONE;
`endif
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef OUTRAM_HDR_EN
  logic [15:0] w_hdr;
  assign w_hdr = 16'(r_byte_cnt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_end_pend <= 1'b0;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_byte_cnt <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      // done trails the DONE state so it follows the final RAM write.
      r_done  <= (r_state == DONE);
      if (r_state == IDLE) begin
        r_ptr      <= BASE;
        r_end_pend <= 1'b0;
        if (start) begin
          r_byte_cnt <= '0;
          r_ovf      <= 1'b0;
        end
      end
      if (r_state == RUN && end_req) r_end_pend <= 1'b1;
      if (w_pop) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_we       <= 1'b1;
          r_addr     <= r_ptr[ADDR_W-1:0];
          r_din      <= lzw_byte;
          r_ptr      <= r_ptr + 1'b1;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
`ifdef OUTRAM_HDR_EN
      if (r_state == HDR0) begin
        r_we   <= 1'b1;
        r_addr <= '0;
        r_din  <= w_hdr[15:8];
      end
      if (r_state == HDR1) begin
        r_we   <= 1'b1;
        r_addr <= ADDR_W'(1);
        r_din  <= w_hdr[7:0];
      end
`endif
    end
  end

  assign read_data  = w_pop;
  assign ram_we_b   = r_we;
  assign ram_addr_b = r_addr;
  assign ram_din_b  = r_din;
  assign byte_cnt   = r_byte_cnt;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_outram_wr.sv
// Directed bench for outram_wr with a behavioural 13-bit code packer and IO RAM model.
module tb_outram_wr;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef OUTRAM_HDR_EN
  localparam int BASE  = 2;
  localparam int HDR_W = 2;
`else
  localparam int BASE  = 0;
  localparam int HDR_W = 0;
`endif
  localparam int CAP = DEPTH - BASE;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, end_req, write_data, write_sp;
  logic              valid_dcnt, tc_outreg;
  logic [7:0]        lzw_byte;
  logic              read_data, ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [7:0]        ram_din_b;
  logic [ADDR_W:0]   byte_cnt;
  logic              busy, done, ovf;
  logic [12:0]       tb_code;

  int n_checks = 0;
  int n_errors = 0;

  outram_wr #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .end_req(end_req),
    .write_data(write_data), .write_sp(write_sp), .valid_dcnt(valid_dcnt),
    .tc_outreg(tc_outreg), .lzw_byte(lzw_byte), .read_data(read_data),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .byte_cnt(byte_cnt), .busy(busy), .done(done), .ovf(ovf)
  );

  // packer model: MSB-first bit buffer, 13-bit codes in, bytes out
  logic [255:0] pk_buf = '0;
  int           pk_cnt = 0;
  int           n_flush = 0;
  always @(posedge clk) begin : pk_model
    logic [255:0] b;
    logic [255:0] w;
    int           c;
    b = pk_buf;
    c = pk_cnt;
    if (rst) begin
      b = '0;
      c = 0;
    end else begin
      if (read_data) begin
        if (c >= 8) begin
          b = b << 8;
          c = c - 8;
        end else begin
          b = '0;
          c = 0;
          n_flush <= n_flush + 1;
        end
      end
      if (write_data || write_sp) begin
        w = '0;
        w[12:0] = write_sp ? 13'h1FFF : tb_code;
        b = b | (w << (256 - 13 - c));
        c = c + 13;
      end
    end
    pk_buf <= b;
    pk_cnt <= c;
  end
  assign valid_dcnt = (pk_cnt >= 8);
  assign tc_outreg  = (pk_cnt == 0);
  assign lzw_byte   = pk_buf[255:248];

  // RAM model, cumulative counters (bench takes baselines per stream)
  logic [7:0] mem    [DEPTH];
  int         wr_cnt [DEPTH] = '{default: 0};
  int         n_wr   = 0;
  int         n_done = 0;
  always @(negedge clk) begin
    if (ram_we_b) begin
      mem[ram_addr_b]    <= ram_din_b;
      wr_cnt[ram_addr_b] <= wr_cnt[ram_addr_b] + 1;
      n_wr               <= n_wr + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  int   base_wr, base_done, base_flush;
  int   base_cnt [DEPTH];
  logic last_tc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    base_wr    = n_wr;
    base_done  = n_done;
    base_flush = n_flush;
    for (int a = 0; a < DEPTH; a++) base_cnt[a] = wr_cnt[a];
  endtask

  task automatic start_stream();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_code(input logic [12:0] c);
    @(negedge clk);
    write_data = 1'b1; write_sp = 1'b0; tb_code = c; end_req = 1'b0;
  endtask

  task automatic send_end();
    @(negedge clk); write_data = 1'b0; write_sp = 1'b0; end_req = 1'b1;
    @(negedge clk); end_req = 1'b0;
  endtask

  task automatic finish_stream(input string tag, input int exp_cnt, input int exp_flush,
                               input logic exp_ovf);
    bit              seen = 1'b0;
    logic [ADDR_W:0] cnt_at_done = '0;
    logic            ovf_at_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen        = 1'b1;
        cnt_at_done = byte_cnt;
        ovf_at_done = ovf;
        last_tc     = tc_outreg;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 1);
    check_eq({tag, "_byte_cnt"}, 32'(cnt_at_done), exp_cnt);
    check_eq({tag, "_ovf"}, 32'(ovf_at_done), 32'(exp_ovf));
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, n_done - base_done, 1);
    check_eq({tag, "_flush_cycles"}, n_flush - base_flush, exp_flush);
    check_eq({tag, "_busy_after"}, 32'(busy), 0);
`ifdef OUTRAM_HDR_EN
    check_eq({tag, "_hdr_hi"}, 32'(mem[0]), (exp_cnt >> 8) & 255);
    check_eq({tag, "_hdr_lo"}, 32'(mem[1]), exp_cnt & 255);
`endif
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp_q[$]);
    int once = 0;
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(mem[BASE + i]), 32'(exp_q[i]));
    for (int a = 0; a < DEPTH; a++)
      if (wr_cnt[a] - base_cnt[a] == 1) once++;
    check_eq({tag, "_addr_once"}, once, exp_q.size() + HDR_W);
    check_eq({tag, "_writes"}, n_wr - base_wr, exp_q.size() + HDR_W);
  endtask

  task automatic basic_stream(input string tag, input bit chk_coll);
    logic [7:0] exp_q[$];
    snap();
    start_stream();
    send_code(13'h1ABC);
    send_code(13'h0123);
    #1;
    if (chk_coll) begin
      check_eq("coll_valid", 32'(valid_dcnt), 1);
      check_eq("coll_pop_blocked", 32'(read_data), 0);
    end
    @(negedge clk); write_data = 1'b0; end_req = 1'b1;
    #1;
    if (chk_coll) check_eq("coll_pop_retry", 32'(read_data), 1);
    @(negedge clk); end_req = 1'b0;
    finish_stream(tag, 4, 1, 1'b0);
    exp_q = {8'hD5, 8'hE0, 8'h48, 8'hC0};
    check_bytes(tag, exp_q);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    rst = 1'b1; start = 1'b0; end_req = 1'b0; write_data = 1'b0; write_sp = 1'b0;
    tb_code = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_read_data", 32'(read_data), 0);
    check_eq("rst_we", 32'(ram_we_b), 0);
    check_eq("rst_addr", 32'(ram_addr_b), 0);
    check_eq("rst_byte_cnt", 32'(byte_cnt), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done_ovf", {30'd0, done, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic stream, including a pop/write collision
    basic_stream("basic", 1'b1);

    // exact byte boundary: 8 codes = 104 bits, no flush expected
    snap();
    start_stream();
    for (int i = 0; i < 8; i++) send_code(13'h1FFF);
    send_end();
    finish_stream("bound", 13, 0, 1'b0);
    check_eq("bound_tc_at_exit", 32'(last_tc), 1);
    exp_q = {};
    for (int i = 0; i < 13; i++) exp_q.push_back(8'hFF);
    check_bytes("bound", exp_q);

    // special code last, end_req alongside it, stray start mid-stream
    snap();
    start_stream();
    @(negedge clk); write_data = 1'b1; tb_code = 13'h0001; start = 1'b1;
    @(negedge clk); write_data = 1'b0; write_sp = 1'b1; end_req = 1'b1; start = 1'b0;
    @(negedge clk); write_sp = 1'b0; end_req = 1'b0;
    finish_stream("special", 4, 1, 1'b0);
    exp_q = {8'h00, 8'h0F, 8'hFF, 8'hC0};
    check_bytes("special", exp_q);
    @(negedge clk);
    check_eq("special_no_restart", 32'(busy), 0);

    // overflow: 12 codes = 156 bits -> 19 full bytes + 1 flushed byte
    snap();
    start_stream();
    for (int i = 0; i < 12; i++) send_code(13'h1FFF);
    send_end();
    finish_stream("ovf", CAP, 1, 1'b1);
    exp_q = {};
    for (int i = 0; i < CAP; i++) exp_q.push_back(8'hFF);
    check_bytes("ovf", exp_q);

    // reset while a pop is active
    snap();
    start_stream();
    send_code(13'h1ABC);
    send_code(13'h0001);
    @(negedge clk); write_data = 1'b0;
    #1;
    check_eq("mid_rst_pop_active", 32'(read_data), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_read_data", 32'(read_data), 0);
    check_eq("mid_rst_we", 32'(ram_we_b), 0);
    check_eq("mid_rst_addr", 32'(ram_addr_b), 0);
    check_eq("mid_rst_din", 32'(ram_din_b), 0);
    check_eq("mid_rst_byte_cnt", 32'(byte_cnt), 0);
    check_eq("mid_rst_busy_done_ovf", {29'd0, busy, done, ovf}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_no_write", n_wr - base_wr, 0);
    basic_stream("after_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
